// File: rtl/fighter_motion_pkg.sv
// Game-wide placement constants, fighter state type and counter sizing helper.
// Pure declarations; no logic.
package fighter_motion_pkg;

   localparam int MAP_X    = 320;
   localparam int LIMIT_X  = 300;
   localparam int PLAYER_X = 40;
   localparam int MAP_Y    = 240;
   localparam int PLAYER_Y = 40;

   localparam int STEP_X   = 4;
   localparam int JUMP_V   = 20;
   localparam int JUMP_G   = 4;
   localparam int JUMP_MAX = 10;

   localparam int DASH_T_DEF  = 3;
   localparam int DASH_CD_DEF = 8;
   localparam int KNOCK_T_DEF = 4;
   localparam int DASH_MUL    = 3;
   localparam int KNOCK_MUL   = 2;

   typedef enum logic [1:0] {
      ST_GROUND,
      ST_JUMP,
      ST_DASH,
      ST_HIT
   } fighter_state_t;

   // Bits needed to hold 0..n, never less than one.
   function automatic int cnt_w(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/fighter_motion_if.sv
// Button levels in, registered position and decoded pose flags out.
// The game-control layer drives the master side; fighter_motion is the slave.
interface fighter_motion_if;
   logic               tick;
   logic               right;
   logic               left;
   logic               jump;
   logic               squat;
   logic               defend;
   logic               dash;
   logic               hit;
   logic               hit_dir;
   logic signed [10:0] x;
   logic signed [9:0]  y;
   logic               isD;
   logic               isQ;
   logic               isJ;
   logic               isH;
   logic               facing;
   logic               dash_rdy;

   modport master (
      output tick, right, left, jump, squat, defend, dash, hit, hit_dir,
      input  x, y, isD, isQ, isJ, isH, facing, dash_rdy
   );

   modport slave (
      input  tick, right, left, jump, squat, defend, dash, hit, hit_dir,
      output x, y, isD, isQ, isJ, isH, facing, dash_rdy
   );
endinterface

// File: rtl/fighter_jump_arc.sv
// Jump height y = Y_GROUND + V*j - floor(G*j*j/2), clamped to at least Y_GROUND.
// Combinational; the caller registers the result.
module fighter_jump_arc #(
   parameter int V        = 20,
   parameter int G        = 4,
   parameter int Y_GROUND = -200,
   parameter int JW       = 4
) (
   input  logic [JW-1:0]     jcnt,
   output logic signed [9:0] y
);
   localparam logic signed [15:0] V16 = 16'(V);
   localparam logic signed [15:0] G16 = 16'(G);
   localparam logic signed [15:0] Y16 = 16'(Y_GROUND);

   logic signed [15:0] j;
   logic signed [15:0] h;

   always_comb begin
      j = 16'(jcnt);
      h = Y16 + V16 * j - ((G16 * j * j) >>> 1);
      if (h < Y16) h = Y16;
   end

   assign y = h[9:0];
endmodule

// File: rtl/fighter_motion.sv
// Per-fighter motion FSM (ground/jump/dash/hit); x, y, facing and counters update on tick.
// Registered state reflects inputs at the sampling edge; flags decode state plus live buttons.
module fighter_motion
   import fighter_motion_pkg::*;
#(
   parameter int X_MIN      = MAP_X - LIMIT_X,
   parameter int X_MAX      = MAP_X - PLAYER_X,
   parameter int X_RESET    = X_MAX,
   parameter int Y_GROUND   = -MAP_Y + PLAYER_Y,
   parameter int STEP       = STEP_X,
   parameter int V          = JUMP_V,
   parameter int G          = JUMP_G,
   parameter int MAX_J      = JUMP_MAX,
   parameter int DASH_STEP  = DASH_MUL * STEP_X,
   parameter int DASH_T     = DASH_T_DEF,
   parameter int DASH_CD    = DASH_CD_DEF,
   parameter int KNOCK_STEP = KNOCK_MUL * STEP_X,
   parameter int KNOCK_T    = KNOCK_T_DEF,
   parameter int FACE_RESET = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   fighter_motion_if.slave  fm
);
   localparam int JW = cnt_w(MAX_J);
   localparam int DW = cnt_w(DASH_T);
   localparam int CW = cnt_w(DASH_CD);
   localparam int KW = cnt_w(KNOCK_T);

   localparam logic [JW-1:0] J_LAST = JW'(MAX_J);
   localparam logic [DW-1:0] D_LAST = DW'(DASH_T);
   localparam logic [KW-1:0] K_LAST = KW'(KNOCK_T);
   localparam logic [CW-1:0] CD_LD  = CW'(DASH_CD);

   localparam logic signed [11:0] STEP12  = 12'(STEP);
   localparam logic signed [11:0] DSTEP12 = 12'(DASH_STEP);
   localparam logic signed [11:0] KSTEP12 = 12'(KNOCK_STEP);
   localparam logic signed [11:0] XMIN12  = 12'(X_MIN);
   localparam logic signed [11:0] XMAX12  = 12'(X_MAX);
   localparam logic signed [10:0] XRST    = 11'(X_RESET);
   localparam logic signed [9:0]  YGND    = 10'(Y_GROUND);
   localparam logic               FACE_RST = (FACE_RESET != 0);

   fighter_state_t     st;
   logic signed [10:0] x_q;
   logic signed [9:0]  y_q;
   logic [JW-1:0]      jcnt;
   logic [JW-1:0]      jcnt_inc;
   logic [DW-1:0]      dcnt;
   logic [KW-1:0]      kcnt;
   logic [CW-1:0]      cd;
   logic               facing_q;
   logic               dash_dir;
   logic               knock_dir;
   logic               dash_dir_new;
   logic signed [9:0]  y_arc;
   logic signed [11:0] walk_d;
   logic signed [11:0] knock_in;

   function automatic logic signed [10:0] clamp_move(input logic signed [10:0] xc,
                                                     input logic signed [11:0] d);
      logic signed [11:0] s;
      s = {xc[10], xc} + d;
      if (s < XMIN12)      s = XMIN12;
      else if (s > XMAX12) s = XMAX12;
      return s[10:0];
   endfunction

   // The arc is evaluated one index ahead so y lands on f(jcnt) once jcnt advances.
   assign jcnt_inc = jcnt + JW'(1);

   fighter_jump_arc #(
      .V        (V),
      .G        (G),
      .Y_GROUND (Y_GROUND),
      .JW       (JW)
   ) u_arc (
      .jcnt (jcnt_inc),
      .y    (y_arc)
   );

   always_comb begin
      walk_d = 12'sd0;
      if (fm.right)     walk_d = STEP12;
      else if (fm.left) walk_d = -STEP12;
   end

   assign knock_in     = fm.hit_dir ? KSTEP12 : -KSTEP12;
   assign dash_dir_new = fm.right ? 1'b1 : (fm.left ? 1'b0 : facing_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st        <= ST_GROUND;
         x_q       <= XRST;
         y_q       <= YGND;
         jcnt      <= '0;
         dcnt      <= '0;
         kcnt      <= '0;
         cd        <= '0;
         facing_q  <= FACE_RST;
         dash_dir  <= 1'b0;
         knock_dir <= 1'b0;
      end else if (fm.tick) begin
         cd <= (cd != '0) ? cd - CW'(1) : '0;
         if ((st == ST_GROUND || st == ST_JUMP) && (fm.right || fm.left))
            facing_q <= fm.right;
         case (st)
            ST_GROUND: begin
               y_q <= YGND;
               if (fm.hit && !fm.defend) begin
                  st        <= ST_HIT;
                  knock_dir <= fm.hit_dir;
                  kcnt      <= KW'(1);
                  x_q       <= clamp_move(x_q, knock_in);
               end else if (fm.jump) begin
                  st   <= ST_JUMP;
                  jcnt <= '0;
               end else if (fm.dash && cd == '0) begin
                  st       <= ST_DASH;
                  dash_dir <= dash_dir_new;
                  dcnt     <= DW'(1);
                  x_q      <= clamp_move(x_q, dash_dir_new ? DSTEP12 : -DSTEP12);
               end else if (!fm.squat && !fm.defend) begin
                  x_q <= clamp_move(x_q, walk_d);
               end
            end
            ST_JUMP: begin
               if (fm.hit) begin
                  st        <= ST_HIT;
                  jcnt      <= '0;
                  y_q       <= YGND;
                  knock_dir <= fm.hit_dir;
                  kcnt      <= KW'(1);
                  x_q       <= clamp_move(x_q, knock_in);
               end else begin
                  x_q <= clamp_move(x_q, walk_d);
                  if (jcnt == J_LAST) begin
                     st   <= ST_GROUND;
                     jcnt <= '0;
                     y_q  <= YGND;
                  end else begin
                     jcnt <= jcnt_inc;
                     y_q  <= y_arc;
                  end
               end
            end
            ST_DASH: begin
               y_q <= YGND;
               if (fm.hit) begin
                  st        <= ST_HIT;
                  dcnt      <= '0;
                  cd        <= CD_LD;
                  knock_dir <= fm.hit_dir;
                  kcnt      <= KW'(1);
                  x_q       <= clamp_move(x_q, knock_in);
               end else if (dcnt >= D_LAST) begin
                  st   <= ST_GROUND;
                  dcnt <= '0;
                  cd   <= CD_LD;
               end else begin
                  dcnt <= dcnt + DW'(1);
                  x_q  <= clamp_move(x_q, dash_dir ? DSTEP12 : -DSTEP12);
               end
            end
            ST_HIT: begin
               y_q <= YGND;
               if (kcnt >= K_LAST) begin
                  st   <= ST_GROUND;
                  kcnt <= '0;
               end else begin
                  kcnt <= kcnt + KW'(1);
                  x_q  <= clamp_move(x_q, knock_dir ? KSTEP12 : -KSTEP12);
               end
            end
            default: st <= ST_GROUND;
         endcase
      end
   end

   assign fm.x        = x_q;
   assign fm.y        = y_q;
   assign fm.facing   = facing_q;
   assign fm.isD      = fm.defend && (st == ST_GROUND);
   assign fm.isQ      = fm.squat && (st == ST_GROUND);
   assign fm.isJ      = (st == ST_JUMP);
   assign fm.isH      = (st == ST_HIT);
   assign fm.dash_rdy = (st == ST_GROUND) && (cd == '0);
endmodule

// File: tb/tb_fighter_motion.sv
// Bench for fighter_motion: directed vector table, hand sequences, then random
// buttons against a tick-level behavioural model of the motion rules.
module tb_fighter_motion;
   localparam int XMIN = 0, XMAX = 100, XRST = 100, YG = -200, STEP = 4;
   localparam int VJ = 20, GJ = 4, MAXJ = 10, DSTEP = 12, DT = 3, DCD = 5;
   localparam int KSTEP = 8, KT = 2;

   localparam logic [8:0] T  = 9'h100, R  = 9'h080, L = 9'h040, J = 9'h020;
   localparam logic [8:0] SQ = 9'h010, DF = 9'h008, DS = 9'h004, H = 9'h002, HD = 9'h001;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   fighter_motion_if fm();

   fighter_motion #(
      .X_MIN(XMIN), .X_MAX(XMAX), .X_RESET(XRST), .Y_GROUND(YG), .STEP(STEP),
      .V(VJ), .G(GJ), .MAX_J(MAXJ), .DASH_STEP(DSTEP), .DASH_T(DT), .DASH_CD(DCD),
      .KNOCK_STEP(KSTEP), .KNOCK_T(KT), .FACE_RESET(0)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .fm    (fm)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [8:0] btn;
      int         ex;
      int         ey;
      logic [5:0] ef;   // {isD, isQ, isJ, isH, facing, dash_rdy}
   } vec_t;
   vec_t tbl[$];

   task automatic add(input logic [8:0] b, input int ex, input int ey, input logic [5:0] ef);
      vec_t v;
      v.btn = b; v.ex = ex; v.ey = ey; v.ef = ef;
      tbl.push_back(v);
   endtask

   task automatic apply(input logic [8:0] b);
      {fm.tick, fm.right, fm.left, fm.jump, fm.squat, fm.defend, fm.dash, fm.hit, fm.hit_dir} = b;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [26:0] pack(input int ex, input int ey, input logic [5:0] f);
      return {11'(ex), 10'(ey), f};
   endfunction

   task automatic check(input string name, input logic [26:0] exp);
      logic [26:0] got;
      got = {fm.x, fm.y, fm.isD, fm.isQ, fm.isJ, fm.isH, fm.facing, fm.dash_rdy};
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got x=%0d y=%0d flags=%b, want x=%0d y=%0d flags=%b", name,
                  $signed(got[26:16]), $signed(got[15:6]), got[5:0],
                  $signed(exp[26:16]), $signed(exp[15:6]), exp[5:0]);
      end
   endtask

   // ---------------- behavioural model ----------------
   localparam int M_STAND = 0, M_AIR = 1, M_DASH = 2, M_STUN = 3;
   int m_mode, m_x, m_y, m_face, m_cd, m_k, m_left, m_dir;

   function automatic int clampx(input int v);
      return (v < XMIN) ? XMIN : ((v > XMAX) ? XMAX : v);
   endfunction

   function automatic int arc(input int k);
      int v;
      v = YG + VJ * k - (GJ * k * k) / 2;
      return (v < YG) ? YG : v;
   endfunction

   task automatic model_reset();
      m_mode = M_STAND; m_x = XRST; m_y = YG; m_face = 0;
      m_cd = 0; m_k = 0; m_left = 0; m_dir = 0;
   endtask

   task automatic stun_enter();
      m_mode = M_STUN;
      m_dir  = fm.hit_dir ? 1 : -1;
      m_x    = clampx(m_x + KSTEP * m_dir);
      m_left = KT - 1;
      m_y    = YG;
      m_k    = 0;
   endtask

   task automatic model_tick();
      int walk, cd_next;
      walk    = fm.right ? STEP : (fm.left ? -STEP : 0);
      cd_next = (m_cd > 0) ? m_cd - 1 : 0;
      if (m_mode == M_STAND || m_mode == M_AIR) begin
         if (fm.right)     m_face = 1;
         else if (fm.left) m_face = 0;
      end
      case (m_mode)
         M_STAND: begin
            m_y = YG;
            if (fm.hit && !fm.defend) stun_enter();
            else if (fm.jump) begin
               m_mode = M_AIR; m_k = 0;
            end else if (fm.dash && m_cd == 0) begin
               m_dir  = fm.right ? 1 : (fm.left ? -1 : (m_face != 0 ? 1 : -1));
               m_mode = M_DASH;
               m_left = DT - 1;
               m_x    = clampx(m_x + DSTEP * m_dir);
            end else if (!fm.squat && !fm.defend) m_x = clampx(m_x + walk);
         end
         M_AIR: begin
            if (fm.hit) stun_enter();
            else begin
               m_x = clampx(m_x + walk);
               if (m_k == MAXJ) begin
                  m_mode = M_STAND; m_k = 0; m_y = YG;
               end else begin
                  m_k++; m_y = arc(m_k);
               end
            end
         end
         M_DASH: begin
            if (fm.hit) begin
               stun_enter(); cd_next = DCD;
            end else if (m_left > 0) begin
               m_x = clampx(m_x + DSTEP * m_dir); m_left--;
            end else begin
               m_mode = M_STAND; cd_next = DCD;
            end
         end
         default: begin
            if (m_left > 0) begin
               m_x = clampx(m_x + KSTEP * m_dir); m_left--;
            end else m_mode = M_STAND;
         end
      endcase
      m_cd = cd_next;
   endtask

   function automatic logic [5:0] m_flags();
      logic st;
      st = (m_mode == M_STAND);
      return {fm.defend && st, fm.squat && st, m_mode == M_AIR, m_mode == M_STUN,
              m_face != 0, st && (m_cd == 0)};
   endfunction

   // ---------------- test sequence ----------------
   int ay[11] = '{-200, -182, -168, -158, -152, -150, -152, -158, -168, -182, -200};

   initial begin
      logic [8:0] b;

      // Jump arc from x=100, facing +x; a second jump at index 3 is ignored.
      for (int k = 0; k < 11; k++)
         add((k == 0 || k == 3) ? (T | J) : T, 100, ay[k], 6'b001010);
      add(T, 100, -200, 6'b000011);
      for (int k = 1; k <= 12; k++) add(T | L, 100 - 4 * k, -200, 6'b000001);
      // Positions stay on the 4-unit grid, so the dash and hit scenarios start at x=52.
      add(T | DS | R, 64, -200, 6'b000010);
      add(T, 76, -200, 6'b000010);
      add(T, 88, -200, 6'b000010);
      add(T, 88, -200, 6'b000010);
      for (int k = 0; k < 4; k++) add(T | DS, 88, -200, 6'b000010);
      add(T | DS, 88, -200, 6'b000011);
      for (int k = 1; k <= 9; k++) add(T | L, 88 - 4 * k, -200, 6'b000001);
      add(T | DF | H, 52, -200, 6'b100001);
      add(T | SQ | L, 52, -200, 6'b010001);
      add(T | J, 52, -200, 6'b001000);
      add(T, 52, -182, 6'b001000);
      add(T | H | HD, 60, -200, 6'b000100);
      add(T, 68, -200, 6'b000100);
      add(T, 68, -200, 6'b000001);

      apply(9'h000);
      repeat (2) @(posedge clk);
      #1;
      check("reset", pack(100, -200, 6'b000001));
      rst_n = 1'b1;

      apply(T | L);
      for (int k = 1; k <= 30; k++) begin
         step();
         check($sformatf("clamp_left%0d", k), pack((100 - 4 * k < 0) ? 0 : 100 - 4 * k, -200, 6'b000001));
      end
      apply(T | R);
      for (int k = 1; k <= 30; k++) begin
         step();
         check($sformatf("clamp_right%0d", k), pack((4 * k > 100) ? 100 : 4 * k, -200, 6'b000011));
      end

      for (int i = 0; i < tbl.size(); i++) begin
         apply(tbl[i].btn);
         step();
         check($sformatf("vec%0d", i), pack(tbl[i].ex, tbl[i].ey, tbl[i].ef));
      end

      // tick gating mid-jump: y and arc index must freeze.
      apply(T | J); step();
      apply(T); repeat (3) step();
      check("gate_pre", pack(68, -158, 6'b001000));
      apply(J | H | L | DS);
      for (int k = 0; k < 5; k++) begin
         step();
         check($sformatf("gate_hold%0d", k), pack(68, -158, 6'b001000));
      end
      apply(T); step();
      check("gate_resume", pack(68, -152, 6'b001000));
      repeat (6) step();
      check("gate_last_arc", pack(68, -200, 6'b001000));
      step();
      check("gate_land", pack(68, -200, 6'b000001));

      // Asynchronous reset in the middle of a dash.
      apply(T | DS | R); step();
      check("dash_entry", pack(80, -200, 6'b000010));
      apply(T);
      #2 rst_n = 1'b0;
      #1 check("async_rst", pack(100, -200, 6'b000001));
      #2 rst_n = 1'b1;
      model_reset();

      for (int i = 0; i < 3000; i++) begin
         b = 9'h000;
         if ($urandom_range(0, 7) != 0) b |= T;
         case ($urandom_range(0, 3))
            1: b |= R;
            2: b |= L;
            3: if ($urandom_range(0, 3) == 0) b |= (R | L);
            default: ;
         endcase
         if ($urandom_range(0, 11) == 0) b |= J;
         if ($urandom_range(0, 7) == 0)  b |= SQ;
         if ($urandom_range(0, 7) == 0)  b |= DF;
         if ($urandom_range(0, 5) == 0)  b |= DS;
         if ($urandom_range(0, 15) == 0) b |= H;
         if ($urandom_range(0, 1) == 0)  b |= HD;
         apply(b);
         step();
         if (b[8]) model_tick();
         check($sformatf("rand%0d", i), pack(m_x, m_y, m_flags()));
         if ($urandom_range(0, 399) == 0) begin
            #2 rst_n = 1'b0;
            #1 model_reset();
            check($sformatf("rand_rst%0d", i), pack(m_x, m_y, m_flags()));
            rst_n = 1'b1;
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
